vxm_issue_sequencer: RTL

- Upstream stage of the vector execution unit (VXM).
- Accepts one instruction (opcode) and then collects two operand beats from the operand stream.
- Issues one single-cycle `vxm_enable` pulse to the VXM, waits out the VXM's registered latency, captures `vxm_result`, and presents it on a valid/ready result stream.
- Serialises work: one instruction in flight at a time.

---
 rtl/vxm_issue_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vxm_issue_sequencer.sv
// Issue sequencer for the VXM: takes one opcode, two operand beats, pulses the VXM,
// waits out its latency and hands the captured result to a valid/ready stream.
module vxm_issue_sequencer #(
    parameter int unsigned MIN_VEC_LENGTH = 16,
    parameter int unsigned VXM_LATENCY    = 1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [1:0]                instr_op,
    input  logic                      opnd_valid,
    output logic                      opnd_ready,
    input  logic [MIN_VEC_LENGTH-1:0] opnd_data,
    output logic                      vxm_enable,
    output logic [1:0]                operation,
    output logic [MIN_VEC_LENGTH-1:0] operand1,
    output logic [MIN_VEC_LENGTH-1:0] operand2,
    input  logic [MIN_VEC_LENGTH-1:0] vxm_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [MIN_VEC_LENGTH-1:0] res_data,
    output logic                      res_err,
    output logic [CNT_WIDTH-1:0]      done_count
);

    localparam int unsigned LatW = $clog2(VXM_LATENCY + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetchA,
        StFetchB,
        StIssue,
        StWait,
        StResult
    } state_e;

    state_e                    state_q, state_d;
    logic                      instr_ready_q, opnd_ready_q;
    logic [1:0]                op_q, op_d;
    logic [MIN_VEC_LENGTH-1:0] opa_q, opa_d;
    logic [MIN_VEC_LENGTH-1:0] opb_q, opb_d;
    logic [LatW-1:0]           lat_q, lat_d;
    logic [MIN_VEC_LENGTH-1:0] res_data_q, res_data_d;
    logic                      res_err_q, res_err_d;
    logic [CNT_WIDTH-1:0]      done_q, done_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        lat_d      = lat_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        done_d     = done_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid && instr_ready_q) begin
                    op_d    = instr_op;
                    state_d = StFetchA;
                end
            end
            StFetchA: begin
                if (opnd_valid && opnd_ready_q) begin
                    opa_d   = opnd_data;
                    state_d = StFetchB;
                end
            end
            StFetchB: begin
                if (opnd_valid && opnd_ready_q) begin
                    opb_d = opnd_data;
                    // Illegal opcodes never reach the VXM; they report an error result.
                    if (op_q == 2'b11) begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = StResult;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                lat_d   = LatW'(VXM_LATENCY);
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == LatW'(1)) begin
                    res_data_d = vxm_result;
                    res_err_d  = 1'b0;
                    state_d    = StResult;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StResult: begin
                if (res_ready) begin
                    done_d  = done_q + CNT_WIDTH'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            instr_ready_q <= 1'b0;
            opnd_ready_q  <= 1'b0;
            op_q          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            lat_q         <= '0;
            res_data_q    <= '0;
            res_err_q     <= 1'b0;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            instr_ready_q <= (state_d == StIdle);
            opnd_ready_q  <= (state_d == StFetchA) || (state_d == StFetchB);
            op_q          <= op_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            lat_q         <= lat_d;
            res_data_q    <= res_data_d;
            res_err_q     <= res_err_d;
            done_q        <= done_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign opnd_ready  = opnd_ready_q;
    assign vxm_enable  = (state_q == StIssue);
    assign res_valid   = (state_q == StResult);
    assign operation   = op_q;
    assign operand1    = opa_q;
    assign operand2    = opb_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign done_count  = done_q;

endmodule
